// File: rtl/spi_wavegen_pkg.sv
// Shared types for spi_wavegen_mc: waveform codes, frame-width helpers and the
// quarter-wave sine table generator.
package spi_wavegen_pkg;

    typedef enum logic [1:0] {
        WF_SINE   = 2'b00,
        WF_SQUARE = 2'b01,
        WF_TRI    = 2'b10,
        WF_SAW    = 2'b11
    } wform_e;

    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    function automatic int pkt_width(input int n_ch, input int div_w);
        return ch_width(n_ch) + div_w + 2;
    endfunction

    // round((2^(dac_w-1)-1) * sin(2*pi*idx/2^ph_w)); int'() of a real rounds to nearest.
    function automatic int sine_quarter(input int idx, input int ph_w, input int dac_w);
        real amp;
        real ang;
        amp = real'((1 << (dac_w - 1)) - 1);
        ang = 6.283185307179586 * real'(idx) / real'(1 << ph_w);
        return int'(amp * $sin(ang));
    endfunction

endpackage

// File: rtl/spi_wavegen_rx.sv
// Write-only SPI mode-0 slave: synchronises the pins, shifts in {ch, div, wform}
// and validates the frame length and channel on the chip-select release.
module spi_wavegen_rx
    import spi_wavegen_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int DIV_W = 16,
    localparam int CH_W  = ch_width(N_CH),
    localparam int PKT_W = pkt_width(N_CH, DIV_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk_i,
    input  logic             cs_n_i,
    input  logic             mosi_i,
    output logic [CH_W-1:0]  ch_o,
    output logic [DIV_W-1:0] div_o,
    output wform_e           wform_o,
    output logic             commit_o,
    output logic             err_o
);

    localparam int BC_W = $clog2(PKT_W + 2);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(PKT_W);
    localparam logic [BC_W-1:0] BC_MAX  = BC_W'(PKT_W + 1);

    logic [2:0]       sclk_q, cs_q;
    logic [1:0]       mosi_q;
    logic             active_q, active_d;
    logic [PKT_W-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]  bcnt_q, bcnt_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [DIV_W-1:0] div_q, div_d;
    wform_e           wform_q, wform_d;
    logic             commit_q, commit_d, err_q, err_d;
    logic             sclk_rise, cs_fall, cs_rise, frame_ok;
    logic [CH_W-1:0]  rx_ch;

    // Bit [2] of each synchroniser is the previous synchronised value, used for edge detect.
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign rx_ch     = shreg_q[PKT_W-1 -: CH_W];
    assign frame_ok  = (bcnt_q == BC_FULL) && ({1'b0, rx_ch} < (CH_W + 1)'(N_CH));

    // active_q gates everything so a frame cut by reset is ignored until the next cs_n fall.
    always_comb begin
        active_d = active_q;
        shreg_d  = shreg_q;
        bcnt_d   = bcnt_q;
        ch_d     = ch_q;
        div_d    = div_q;
        wform_d  = wform_q;
        commit_d = 1'b0;
        err_d    = 1'b0;
        if (cs_fall) begin
            active_d = 1'b1;
            shreg_d  = '0;
            bcnt_d   = '0;
        end else if (active_q && cs_rise) begin
            active_d = 1'b0;
            if (frame_ok) begin
                commit_d = 1'b1;
                ch_d     = rx_ch;
                div_d    = shreg_q[2 +: DIV_W];
                wform_d  = wform_e'(shreg_q[1:0]);
            end else begin
                err_d = 1'b1;
            end
        end else if (active_q && sclk_rise) begin
            shreg_d = {shreg_q[PKT_W-2:0], mosi_q[1]};
            if (bcnt_q != BC_MAX) bcnt_d = bcnt_q + BC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q   <= '0;
            cs_q     <= '1;
            mosi_q   <= '0;
            active_q <= 1'b0;
            shreg_q  <= '0;
            bcnt_q   <= '0;
            ch_q     <= '0;
            div_q    <= '0;
            wform_q  <= WF_SINE;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sclk_q   <= {sclk_q[1:0], sclk_i};
            cs_q     <= {cs_q[1:0], cs_n_i};
            mosi_q   <= {mosi_q[0], mosi_i};
            active_q <= active_d;
            shreg_q  <= shreg_d;
            bcnt_q   <= bcnt_d;
            ch_q     <= ch_d;
            div_q    <= div_d;
            wform_q  <= wform_d;
            commit_q <= commit_d;
            err_q    <= err_d;
        end
    end

    assign ch_o     = ch_q;
    assign div_o    = div_q;
    assign wform_o  = wform_q;
    assign commit_o = commit_q;
    assign err_o    = err_q;

endmodule

// File: rtl/spi_wavegen_mc.sv
// Multi-channel SPI-programmed waveform generator (sine/square/triangle/saw).
// Define SPI_WAVEGEN_SINE_EN to build the sine LUT; otherwise mode 00 aliases triangle.
module spi_wavegen_mc
    import spi_wavegen_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int DIV_W = 16,
    parameter int DAC_W = 10,
    parameter int PH_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic [N_CH*DAC_W-1:0] dac,
    output logic                  cfg_stb,
    output logic                  frame_err
);

    localparam int CH_W = ch_width(N_CH);

    logic [CH_W-1:0]  rx_ch;
    logic [DIV_W-1:0] rx_div;
    wform_e           rx_wform;
    logic             rx_commit, rx_err;

    spi_wavegen_rx #(.N_CH(N_CH), .DIV_W(DIV_W)) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk_i   (sclk),
        .cs_n_i   (cs_n),
        .mosi_i   (mosi),
        .ch_o     (rx_ch),
        .div_o    (rx_div),
        .wform_o  (rx_wform),
        .commit_o (rx_commit),
        .err_o    (rx_err)
    );

    assign cfg_stb   = rx_commit;
    assign frame_err = rx_err;

`ifdef SPI_WAVEGEN_SINE_EN
    localparam int QN = 1 << (PH_W - 2);
    localparam logic [DAC_W-1:0] MID = DAC_W'(1) << (DAC_W - 1);
    logic [DAC_W-2:0] sine_lut [QN+1];
    for (genvar i = 0; i <= QN; i++) begin : g_lut
        assign sine_lut[i] = (DAC_W - 1)'(sine_quarter(i, PH_W, DAC_W));
    end
`endif

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
        wform_e           wform_q, wform_d;
        logic [PH_W-1:0]  phase_q, phase_d;
        logic [DAC_W-1:0] dac_q, dac_d;
        logic [PH_W-2:0]  tri_t;
        logic [DAC_W-1:0] saw_v, tri_v, sq_v, sine_v;
        logic             running, step, hit;

        assign tri_t = phase_q[PH_W-1] ? ~phase_q[PH_W-2:0] : phase_q[PH_W-2:0];
        assign sq_v  = phase_q[PH_W-1] ? '0 : '1;

        // Left-align: MSB lands on the DAC MSB, padding or truncating the LSBs.
        if (DAC_W >= PH_W) begin : g_saw_pad
            assign saw_v = DAC_W'(phase_q) << (DAC_W - PH_W);
        end else begin : g_saw_cut
            assign saw_v = DAC_W'(phase_q >> (PH_W - DAC_W));
        end
        if (DAC_W >= PH_W - 1) begin : g_tri_pad
            assign tri_v = DAC_W'(tri_t) << (DAC_W - PH_W + 1);
        end else begin : g_tri_cut
            assign tri_v = DAC_W'(tri_t >> (PH_W - 1 - DAC_W));
        end

`ifdef SPI_WAVEGEN_SINE_EN
        logic [PH_W-2:0]  lut_addr;
        logic [DAC_W-1:0] amp;
        // Odd quadrants mirror the table index; the upper half negates about mid-scale.
        assign lut_addr = phase_q[PH_W-2] ? (PH_W - 1)'(QN) - {1'b0, phase_q[PH_W-3:0]}
                                          : {1'b0, phase_q[PH_W-3:0]};
        assign amp      = {1'b0, sine_lut[lut_addr]};
        assign sine_v   = phase_q[PH_W-1] ? (MID - amp) : (MID + amp);
`else
        assign sine_v = tri_v;
`endif

        // A commit on a step cycle still lets the phase advance; only cnt is restarted.
        always_comb begin
            div_d   = div_q;
            wform_d = wform_q;
            cnt_d   = cnt_q;
            phase_d = phase_q;
            dac_d   = dac_q;
            running = (div_q != '0);
            step    = running && (cnt_q == div_q - DIV_W'(1));
            hit     = rx_commit && (rx_ch == CH_W'(c));
            if (running) begin
                cnt_d = step ? '0 : cnt_q + DIV_W'(1);
                if (step) phase_d = phase_q + PH_W'(1);
                case (wform_q)
                    WF_SINE:   dac_d = sine_v;
                    WF_SQUARE: dac_d = sq_v;
                    WF_TRI:    dac_d = tri_v;
                    default:   dac_d = saw_v;
                endcase
            end
            if (hit) begin
                div_d   = rx_div;
                wform_d = rx_wform;
                cnt_d   = '0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                div_q   <= '0;
                wform_q <= WF_SINE;
                cnt_q   <= '0;
                phase_q <= '0;
                dac_q   <= '0;
            end else begin
                div_q   <= div_d;
                wform_q <= wform_d;
                cnt_q   <= cnt_d;
                phase_q <= phase_d;
                dac_q   <= dac_d;
            end
        end

        assign dac[c*DAC_W +: DAC_W] = dac_q;
    end

endmodule

// File: tb/tb_spi_wavegen_mc.sv
// Directed bench for spi_wavegen_mc: SPI frames at sclk = clk/8, dac sequences
// checked at hand-computed cycle offsets from each cfg_stb pulse.
`timescale 1ns/1ps
module tb_spi_wavegen_mc;

    localparam int N_CH  = 2;
    localparam int DIV_W = 16;
    localparam int DAC_W = 10;
    localparam int PH_W  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sclk  = 1'b0;
    logic cs_n  = 1'b1;
    logic mosi  = 1'b0;
    logic [N_CH*DAC_W-1:0] dac;
    logic cfg_stb, frame_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_cfg    = 0;
    int n_err    = 0;

    spi_wavegen_mc #(.N_CH(N_CH), .DIV_W(DIV_W), .DAC_W(DAC_W), .PH_W(PH_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .dac       (dac),
        .cfg_stb   (cfg_stb),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cfg_stb === 1'b1)   n_cfg <= n_cfg + 1;
        if (frame_err === 1'b1) n_err <= n_err + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_dac(input string tag, input int c, input int exp);
        check(tag, 32'(dac[c*DAC_W +: DAC_W]), exp);
    endtask

    function automatic logic [31:0] frame(input int ch, input int dv, input int wf);
        return (ch << 18) | (dv << 2) | wf;
    endfunction

    task automatic send_frame(input logic [31:0] val, input int nbits);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = val[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
    endtask

    task automatic wait_cfg(output int lat, output int t);
        lat = -1;
        t   = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (cfg_stb === 1'b1) begin
                lat = i;
                t   = cyc;
                break;
            end
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_dac({tag, "_dac0"}, 0, 0);
        chk_dac({tag, "_dac1"}, 1, 0);
        check({tag, "_cfg_stb"}, 32'(cfg_stb), 0);
        check({tag, "_frame_err"}, 32'(frame_err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk_dac({tag, "_post_dac0"}, 0, 0);
        chk_dac({tag, "_post_dac1"}, 1, 0);
    endtask

    initial begin
        int lat, t0, t1, p0, c0, e0;

        // Power-on reset
        repeat (3) @(negedge clk);
        chk_dac("por_dac0", 0, 0);
        chk_dac("por_dac1", 1, 0);
        check("por_cfg_stb", 32'(cfg_stb), 0);
        check("por_frame_err", 32'(frame_err), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Sawtooth ch0, div 4: +4 every 4 clk, wrap after 1024 clk
        send_frame(frame(0, 4, 3), 19);
        wait_cfg(lat, t0);
        check("saw_stb_latency", lat, 3);
        @(negedge clk);
        check("saw_stb_width", 32'(cfg_stb), 0);
        wait_to(t0 + 2);    chk_dac("saw_n2", 0, 0);
        wait_to(t0 + 6);    chk_dac("saw_n6", 0, 4);
        wait_to(t0 + 10);   chk_dac("saw_n10", 0, 8);
        wait_to(t0 + 1022); chk_dac("saw_n1022", 0, 1020);
        wait_to(t0 + 1025); chk_dac("saw_n1025", 0, 1020);
        wait_to(t0 + 1026); chk_dac("saw_wrap", 0, 0);
        chk_dac("saw_ch1_idle", 1, 0);
        check("saw_n_cfg", n_cfg, 1);
        check("saw_n_err", n_err, 0);

        // Square ch1, div 1: 128 clk high, 128 clk low
        send_frame(frame(1, 1, 1), 19);
        wait_cfg(lat, t0);
        check("sq_stb_latency", lat, 3);
        wait_to(t0 + 2);   chk_dac("sq_n2", 1, 1023);
        wait_to(t0 + 129); chk_dac("sq_n129", 1, 1023);
        wait_to(t0 + 130); chk_dac("sq_n130", 1, 0);
        wait_to(t0 + 257); chk_dac("sq_n257", 1, 0);
        wait_to(t0 + 258); chk_dac("sq_n258", 1, 1023);

        // Reset while both channels run
        do_reset("midrst");

        // Triangle ch0, div 2: phase advances every 2 clk
        send_frame(frame(0, 2, 2), 19);
        wait_cfg(lat, t0);
        check("tri_stb_latency", lat, 3);
        wait_to(t0 + 2);   chk_dac("tri_p0", 0, 0);
        wait_to(t0 + 4);   chk_dac("tri_p1", 0, 8);
        wait_to(t0 + 254); chk_dac("tri_p126", 0, 1008);
        wait_to(t0 + 256); chk_dac("tri_p127", 0, 1016);
        wait_to(t0 + 259); chk_dac("tri_p128", 0, 1016);
        wait_to(t0 + 260); chk_dac("tri_p129", 0, 1008);
        wait_to(t0 + 512); chk_dac("tri_p255", 0, 0);

        // Short and long frames aimed at the halted ch1 must be rejected
        c0 = n_cfg;
        e0 = n_err;
        send_frame(frame(1, 5, 3) >> 1, 18);
        repeat (20) @(negedge clk);
        check("bad18_err", n_err, e0 + 1);
        send_frame(frame(1, 5, 3) << 1, 20);
        repeat (20) @(negedge clk);
        check("bad20_err", n_err, e0 + 2);
        check("bad_no_cfg", n_cfg, c0);
        chk_dac("bad_ch1_halted", 1, 0);

        // Retune running ch1 from div 4 to div 1: phase carries over
        send_frame(frame(1, 4, 3), 19);
        wait_cfg(lat, t0);
        check("retune_a_latency", lat, 3);
        send_frame(frame(1, 1, 3), 19);
        wait_cfg(lat, t1);
        check("retune_b_latency", lat, 3);
        p0 = ((t1 - t0) / 4) % 256;
        wait_to(t1 + 2);  chk_dac("retune_n2", 1, p0 * 4);
        wait_to(t1 + 10); chk_dac("retune_n10", 1, ((p0 + 8) % 256) * 4);

        // Mode 00 from phase 0, div 1
        do_reset("prerst");
        send_frame(frame(0, 1, 0), 19);
        wait_cfg(lat, t0);
        check("sine_stb_latency", lat, 3);
`ifdef SPI_WAVEGEN_SINE_EN
        wait_to(t0 + 2);   chk_dac("sine_p0", 0, 512);
        wait_to(t0 + 66);  chk_dac("sine_p64", 0, 1023);
        wait_to(t0 + 130); chk_dac("sine_p128", 0, 512);
        wait_to(t0 + 194); chk_dac("sine_p192", 0, 1);
`else
        wait_to(t0 + 2);   chk_dac("sine_as_tri_p0", 0, 0);
        wait_to(t0 + 66);  chk_dac("sine_as_tri_p64", 0, 512);
        wait_to(t0 + 130); chk_dac("sine_as_tri_p128", 0, 1016);
        wait_to(t0 + 194); chk_dac("sine_as_tri_p192", 0, 504);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_wavegen_mc.md
# spi_wavegen_mc

Multi-channel, parametrised SPI-programmed waveform generator. It produces N_CH independent DAC sample streams from per-channel phase counters, in sine, square, triangle or sawtooth form. Each channel's divider and waveform are loaded through a write-only SPI slave clocked in from the board pins. The block sits between the SPI header pins and the R-2R DAC pin groups in the top level.

## Interface
- N_CH, 2: number of output channels (≥1)
- DIV_W, 16: divider width
- DAC_W, 10: DAC sample width per channel (≥2)
- PH_W, 8: phase counter width; 2^PH_W steps per period (≥3)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- sclk  in  1  SPI clock, asynchronous to clk
- cs_n  in  1  SPI chip select, active low
- mosi  in  1  SPI data, MSB first
- dac  out  N_CH*DAC_W  channel c occupies bits [c*DAC_W +: DAC_W], offset binary
- cfg_stb  out  1  one-cycle pulse when a frame is committed
- frame_err  out  1  one-cycle pulse when a frame is discarded

## Operation
- Frame format: PKT_W = CH_W+DIV_W+2 bits, with CH_W = max(1, $clog2(N_CH)). Fields are {ch, divider, wform}, MSB first.
- sclk, cs_n and mosi each pass through a 2-flop synchroniser. mosi is shifted in on the detected rising edge of synchronised sclk (SPI mode 0).
- Falling edge of synchronised cs_n: clear the bit counter and the shift register.
- Bit counter saturates at PKT_W+1.
- Rising edge of synchronised cs_n:
  - if count == PKT_W and ch < N_CH: commit, pulse cfg_stb;
  - otherwise: pulse frame_err and change nothing.
- Commit: load div[ch] and wform[ch], clear that channel's divider counter, keep its phase (phase-continuous retune).
- Channel engine:
  - div == 0: phase and dac frozen.
  - Otherwise cnt counts 0..div-1. At cnt == div-1: cnt←0, phase←phase+1 (wraps mod 2^PH_W).
  - Output period = div·2^PH_W clk cycles.
- Waveform mapping, with p = phase and "left-align" meaning the MSB goes to dac MSB, then zero-pad or truncate:
  - 00 sine: 512-style offset binary. out = 2^(DAC_W-1) + round((2^(DAC_W-1)-1)·sin(2πp/2^PH_W)).
  - 01 square: p MSB 0 → all ones; 1 → 0.
  - 10 triangle: t = p[MSB] ? ~p[PH_W-2:0] : p[PH_W-2:0]; left-align t.
  - 11 sawtooth: left-align p.
- Reset values:
  - dac = 0 on all channels, cfg_stb = 0, frame_err = 0.
  - All div = 0 (channels halted), all wform = 00, phase = 0, cnt = 0.
  - Receiver idle.
- Reset mid-frame aborts the frame. Nothing is committed, and the next frame starts at the next cs_n fall.

## Timing
- sclk high and low phases must each be ≥3 clk cycles. mosi must be stable from 1 clk before to 3 clk after the sclk rise. Faster sclk is unsupported.
- cs_n rise → cfg_stb on the 3rd clk edge after cs_n is first sampled high. New settings act from the cycle after cfg_stb.
- dac is registered: 1 cycle after a phase change. First phase step after commit comes div cycles after the commit cycle.
- cfg_stb and frame_err are mutually exclusive and each last exactly one cycle.
- A commit to a channel on the same cycle as its phase step: the commit wins (cnt←0) and the step still happens.

## Configuration
- SPI_WAVEGEN_SINE_EN defined: mode 00 is sine, generated from a quarter-wave LUT of 2^(PH_W-2)+1 entries using mirror and negate symmetry.
- Not defined: no LUT is built, and mode 00 produces the triangle output, bit-identical to mode 10.

## Structure
- Package spi_wavegen_pkg:
  - wform_e enum: WF_SINE=00, WF_SQUARE=01, WF_TRI=10, WF_SAW=11;
  - PKT_W/CH_W helper functions;
  - sine quarter-table generation function.
- Sub-module spi_wavegen_rx: synchronisers, edge detect, shift register, bit counter, frame validation. Outputs a ch/div/wform bundle with commit and error pulses.
- The top module holds the per-channel register file, the counters and the waveform mappers in a generate loop.

## Test plan
All scenarios use default parameters, so PKT_W = 19, with sclk at 1/8 of clk.
- Reset: assert rst_n=0 mid-run → dac=0 on both channels, cfg_stb=0, frame_err=0. Release: outputs stay 0 and nothing steps.
- Sawtooth: frame {0, 4, 11} → cfg_stb once; dac[0] rises by 4 every 4 clk (0, 4, … 1020), then wraps to 0 at 1024 clk; dac[1] stays 0.
- Square: frame {1, 1, 01} → dac[1] = 1023 for 128 clk, then 0 for 128 clk, repeating.
- Triangle: {0, 2, 10} → dac[0] reaches 1016 at phases 127 and 128, then descends to 0 at phase 255.
- Bad frames: an 18-bit frame and a 20-bit frame → a frame_err pulse for each, no cfg_stb, channel settings unchanged. A retune of a running channel to div 1 keeps its phase.
- Sine:
  - With SPI_WAVEGEN_SINE_EN, {0, 1, 00} → dac[0] = 512 at p=0, 1023 at p=64, 1 at p=192.
  - Without the macro, the output equals the mode-10 result at the same phase.
